// File: rtl/idrr_stage_if.sv
// IF/ID -> ID/RR data bus: instruction fields in, registered decode fields out.
// master is the ID/RR stage; slave is the IF/ID producer and downstream consumers.
interface idrr_stage_if #(
   parameter int DW = 16
);
   logic [DW-1:0] ifid_instr;
   logic [DW-1:0] ifid_pc;
   logic          ifid_valid;
   logic [DW-1:0] idrr_instr;
   logic [DW-1:0] idrr_pc;
   logic          idrr_valid;
   logic          IDRR_LM;
   logic          IDRR_SM;
   logic [DW-1:0] SE16;
   logic [2:0]    ra_addr;
   logic [2:0]    rb_addr;
   logic [2:0]    rc_addr;

   modport master (
      input  ifid_instr, ifid_pc, ifid_valid,
      output idrr_instr, idrr_pc, idrr_valid, IDRR_LM, IDRR_SM, SE16,
             ra_addr, rb_addr, rc_addr
   );

   modport slave (
      output ifid_instr, ifid_pc, ifid_valid,
      input  idrr_instr, idrr_pc, idrr_valid, IDRR_LM, IDRR_SM, SE16,
             ra_addr, rb_addr, rc_addr
   );
endinterface

// File: rtl/idrr_stage.sv
// ID/RR pipeline register: one-cycle latency from IF/ID to registered instruction and SE16.
// Holds under disable_pipe/hazard_stall (ifid_hold back to IF/ID); flushes seen during an LM/SM hold are deferred.
module idrr_stage #(
   parameter int         DW    = 16,
   parameter logic [3:0] LM_OP = 4'b0110,
   parameter logic [3:0] SM_OP = 4'b0111
) (
   input  logic             clk,
   input  logic             reset,
   idrr_stage_if.master     bus,
   input  logic             disable_pipe,
   input  logic             hazard_stall,
   input  logic             flush,
   output logic             ifid_hold,
   output logic             flush_pending
);

   typedef enum logic [1:0] {RUN, HOLD_LMSM, HOLD_HAZ} state_t;
   typedef enum logic [1:0] {ACT_HOLD, ACT_LOAD, ACT_BUBBLE} act_t;

   state_t        state_q, state_d;
   act_t          act;
   logic          pend_d;
   logic [DW-1:0] instr_q, pc_q, se16_q;
   logic          valid_q;

   function automatic logic [DW-1:0] ext_imm(input logic [DW-1:0] i);
      logic [DW-1:0] r;
      r = '0;
      case (i[DW-1:DW-4])
         LM_OP, SM_OP:                      r = {{(DW-8){1'b0}}, i[7:0]};
         4'b0011:                           r = {i[8:0], {(DW-9){1'b0}}};
         4'b0001, 4'b0100, 4'b0101, 4'b1100: r = {{(DW-6){i[5]}}, i[5:0]};
         4'b1000:                           r = {{(DW-9){i[8]}}, i[8:0]};
         default:                           r = '0;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= RUN;
         flush_pending <= 1'b0;
      end else begin
         state_q       <= state_d;
         flush_pending <= pend_d;
      end
   end

   // disable_pipe outranks flush in every state; that is what makes the flush deferrable.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (disable_pipe)      state_d = HOLD_LMSM;
            else if (flush)        state_d = RUN;
            else if (hazard_stall) state_d = HOLD_HAZ;
         end
         HOLD_LMSM: begin
            if (!disable_pipe)     state_d = RUN;
         end
         HOLD_HAZ: begin
            if (disable_pipe)                state_d = HOLD_LMSM;
            else if (flush || !hazard_stall) state_d = RUN;
         end
         default:                  state_d = RUN;
      endcase
   end

   always_comb begin
      act    = ACT_HOLD;
      pend_d = 1'b0;
      case (state_q)
         RUN, HOLD_HAZ: begin
            if (disable_pipe)       pend_d = flush;
            else if (flush)         act    = ACT_BUBBLE;
            else if (!hazard_stall) act    = ACT_LOAD;
         end
         HOLD_LMSM: begin
            // Leaving the hold always consumes the finished LM/SM, either as a bubble or a fresh load.
            if (disable_pipe)       pend_d = flush_pending | flush;
            else if (flush_pending || flush) act = ACT_BUBBLE;
            else                    act    = ACT_LOAD;
         end
         default:                   act    = ACT_BUBBLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_q <= '0;
         pc_q    <= '0;
         se16_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         case (act)
            ACT_LOAD: begin
               instr_q <= bus.ifid_instr;
               pc_q    <= bus.ifid_pc;
               se16_q  <= ext_imm(bus.ifid_instr);
               valid_q <= bus.ifid_valid;
            end
            ACT_BUBBLE: begin
               instr_q <= '0;
               pc_q    <= '0;
               se16_q  <= '0;
               valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign ifid_hold      = reset & (disable_pipe | hazard_stall);
   assign bus.idrr_instr = instr_q;
   assign bus.idrr_pc    = pc_q;
   assign bus.idrr_valid = valid_q;
   assign bus.SE16       = se16_q;
   assign bus.IDRR_LM    = valid_q & (instr_q[DW-1:DW-4] == LM_OP);
   assign bus.IDRR_SM    = valid_q & (instr_q[DW-1:DW-4] == SM_OP);
   assign bus.ra_addr    = valid_q ? instr_q[11:9] : 3'b0;
   assign bus.rb_addr    = valid_q ? instr_q[8:6]  : 3'b0;
   assign bus.rc_addr    = valid_q ? instr_q[5:3]  : 3'b0;

endmodule
